intc_prio: RTL and testbench
============================

INTC_PRIO -- requirements
Module: intc_prio

Interface
REQ-001 Parameters SHALL be: DW, default 16, bus data width; AW, default 13, bus address width; NCH, default 8, interrupt channel count, legal range 1..DW and at most 16.
REQ-002 Ports SHALL be:
- clk, input, 1, the only clock.
- rst, input, 1, reset; synchronous, active-high.
- din, input, DW, bus write data.
- addr, input, AW, bus word address.
- we, input, 1, write enable, active-high.
- dout, output, DW, registered bus read data.
- intp_i, input, NCH, interrupt source lines.
- int_rdy, input, 1, core accepts the interrupt, active-high.
- int_vld, output, 1, interrupt request to core.
- int_id, output, 4, channel number of the request or interrupt in service.

Function
REQ-003 Register map (word addresses):
- 0 CTRL: [0] GIE, R/W; [1] BUSY, RO; [7:4] active ID, RO.
- 1 EOI: write-only; any write ends service; reads return 0.
- 2 PEND: [NCH-1:0] pending bits; read returns pending; write-1-to-clear.
- 4+k CFGk, one register per channel k<NCH: [0] EN; [2:1] PRIO, 0 is highest; [4:3] trigger mode: 00 high, 01 low, 10 rising, 11 falling.
REQ-004 Reads SHALL update dout one cycle after addr is presented with we low; unmapped or unimplemented bits SHALL read 0; dout SHALL hold its value while we is high.
REQ-005 Each intp_i bit SHALL pass through the input stage S, where S = 1 flop, or 2 flops per REQ-016; S_d is S delayed by one cycle.
REQ-006 Condition per mode: high = S; low = ~S; rising = S & ~S_d; falling = ~S & S_d.
REQ-007 A pending bit SHALL set on the edge following a true condition while its EN is 1; disabling a channel SHALL NOT clear its pending bit, but a pending bit with EN 0 SHALL be ineligible for arbitration.
REQ-008 If set and clear (W1C or acceptance) of the same bit occur in the same cycle, set SHALL win.
REQ-009 Arbitration SHALL select the eligible pending channel with the numerically lowest PRIO; ties SHALL go to the lowest index.
REQ-010 FSM states SHALL be IDLE, REQ and ACT:
- IDLE->REQ when GIE=1 and any channel is eligible; latch the winner into int_id.
- REQ->ACT when int_rdy=1; clear the winner's pending bit on that edge.
- REQ->IDLE if GIE is written to 0; pending is retained.
- ACT->IDLE on an EOI write.
REQ-011 int_vld SHALL be 1 only in REQ; int_id SHALL stay stable throughout REQ and ACT with no preemption; BUSY SHALL be 1 in REQ and ACT.
REQ-012 Latency: with a single-flop stage, a source that is high before edge E0 SHALL give pending=1 after E1 and int_vld=1 after E2; the macro in REQ-016 adds one cycle.
REQ-013 An EOI write in IDLE or REQ SHALL be ignored; GIE=0 in ACT SHALL NOT abort service.

Reset
REQ-014 On rst, all of the following SHALL be 0 on the next edge: dout, int_vld, int_id, GIE, PEND, all CFGk, stage flops, FSM=IDLE.
REQ-015 rst asserted mid-REQ or mid-ACT SHALL drop int_vld at the same edge; no other state survives.

Configuration
REQ-016 Macro INTC_SYNC_EN:
- Defined: the input stage SHALL be a 2-flop synchroniser feeding S.
- Undefined: the input stage SHALL be a single flop.
- Register map and FSM SHALL be unchanged in both builds.

Verification
REQ-017 CFG0=0x01, GIE=1, intp_i[0] pulsed high for 1 cycle -> int_vld at E2 (E3 with the macro), int_id=0; hold int_rdy=0 for 5 cycles -> int_vld stays 1.
REQ-018 CFG2=0x05 (PRIO 2), CFG5=0x01 (PRIO 0), both sources high simultaneously -> int_id=5 first; after int_rdy and an EOI write -> int_id=2.
REQ-019 CFG3=0x11 (rising), intp_i[3] held high 10 cycles -> exactly one pending set and one request; CFG3=0x01 (high) with the same stimulus -> request re-asserts after EOI.
REQ-020 Pending bit 1 set, GIE=0, write PEND=0x0002 -> PEND reads 0x0000 and no request occurs; same-cycle set and clear -> bit stays 1.
REQ-021 In REQ, write GIE=0 -> int_vld=0 the next cycle and the pending bit is retained; rst asserted in ACT -> all outputs read 0, CTRL reads 0x0000.

Source files
------------

// File: rtl/intc_prio.sv
// Prioritised interrupt controller: per-channel trigger/enable/priority, pending
// register and a three-state request handshake. Define INTC_SYNC_EN for a 2-flop input synchroniser.
module intc_prio #(
    parameter int DW  = 16,
    parameter int AW  = 13,
    parameter int NCH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  din,
    input  logic [AW-1:0]  addr,
    input  logic           we,
    output logic [DW-1:0]  dout,
    input  logic [NCH-1:0] intp_i,
    input  logic           int_rdy,
    output logic           int_vld,
    output logic [3:0]     int_id
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACT
    } state_t;

    localparam logic [AW-1:0] CTRL_ADDR = AW'(0);
    localparam logic [AW-1:0] EOI_ADDR  = AW'(1);
    localparam logic [AW-1:0] PEND_ADDR = AW'(2);

    state_t         state;
    state_t         state_nxt;
    logic           gie;
    logic           busy;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] en;
    logic [1:0]     prio [NCH];
    logic [1:0]     mode [NCH];
    logic [NCH-1:0] s;
    logic [NCH-1:0] s_d;
    logic [NCH-1:0] cond;
    logic [NCH-1:0] set_vec;
    logic [NCH-1:0] clr_vec;
    logic [NCH-1:0] elig;
    logic           win_found;
    logic [1:0]     win_prio;
    logic [3:0]     win_id;
    logic           ctrl_wr;
    logic           eoi_wr;
    logic           pend_wr;
    logic [DW-1:0]  rdata;
    logic           unused_din;

    assign ctrl_wr    = we && (addr == CTRL_ADDR);
    assign eoi_wr     = we && (addr == EOI_ADDR);
    assign pend_wr    = we && (addr == PEND_ADDR);
    assign unused_din = ^din;
    assign busy       = (state != IDLE);
    assign int_vld    = (state == REQ);

`ifdef INTC_SYNC_EN
    logic [NCH-1:0] sync1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            s     <= '0;
            s_d   <= '0;
        end else begin
            sync1 <= intp_i;
            s     <= sync1;
            s_d   <= s;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            s   <= '0;
            s_d <= '0;
        end else begin
            s   <= intp_i;
            s_d <= s;
        end
    end
`endif

    always_comb begin
        cond    = '0;
        clr_vec = '0;
        for (int k = 0; k < NCH; k++) begin
            case (mode[k])
                2'b00:   cond[k] = s[k];
                2'b01:   cond[k] = ~s[k];
                2'b10:   cond[k] = s[k] & ~s_d[k];
                default: cond[k] = ~s[k] & s_d[k];
            endcase
            if (pend_wr && din[k])
                clr_vec[k] = 1'b1;
            if ((state == REQ) && int_rdy && (int_id == 4'(k)))
                clr_vec[k] = 1'b1;
        end
    end

    assign set_vec = en & cond;
    assign elig    = pend & en;

    // Strict less-than while scanning upward keeps ties on the lowest index.
    always_comb begin
        win_found = 1'b0;
        win_prio  = 2'd3;
        win_id    = 4'd0;
        for (int k = 0; k < NCH; k++) begin
            if (elig[k] && (!win_found || (prio[k] < win_prio))) begin
                win_found = 1'b1;
                win_prio  = prio[k];
                win_id    = 4'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            gie  <= 1'b0;
            en   <= '0;
            for (int k = 0; k < NCH; k++) begin
                prio[k] <= 2'd0;
                mode[k] <= 2'd0;
            end
        end else begin
            pend <= (pend & ~clr_vec) | set_vec;
            if (ctrl_wr)
                gie <= din[0];
            for (int k = 0; k < NCH; k++) begin
                if (we && (addr == AW'(4 + k))) begin
                    en[k]   <= din[0];
                    prio[k] <= din[2:1];
                    mode[k] <= din[4:3];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            int_id <= 4'd0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && (state_nxt == REQ))
                int_id <= win_id;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (gie && win_found) state_nxt = REQ;
            REQ: begin
                if (int_rdy)
                    state_nxt = ACT;
                else if (ctrl_wr && !din[0])
                    state_nxt = IDLE;
            end
            ACT: if (eoi_wr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (addr == CTRL_ADDR) begin
            rdata[0]   = gie;
            rdata[1]   = busy;
            rdata[7:4] = busy ? int_id : 4'd0;
        end
        if (addr == PEND_ADDR)
            rdata[NCH-1:0] = pend;
        for (int k = 0; k < NCH; k++) begin
            if (addr == AW'(4 + k))
                rdata[4:0] = {mode[k], prio[k], en[k]};
        end
    end

    // Read data only moves on read cycles so a write never disturbs it.
    always_ff @(posedge clk) begin
        if (rst)
            dout <= '0;
        else if (!we)
            dout <= rdata;
    end

endmodule

// File: tb/tb_intc_prio.sv
// Directed self-checking bench for intc_prio: latency, arbitration, trigger modes,
// pending W1C and the GIE/reset interactions of the request handshake.
module tb_intc_prio;

    localparam int DW  = 16;
    localparam int AW  = 13;
    localparam int NCH = 8;
`ifdef INTC_SYNC_EN
    localparam int SYNC = 1;
`else
    localparam int SYNC = 0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  din;
    logic [AW-1:0]  addr;
    logic           we;
    logic [DW-1:0]  dout;
    logic [NCH-1:0] intp_i;
    logic           int_rdy;
    logic           int_vld;
    logic [3:0]     int_id;

    int tests = 0;
    int fails = 0;
    logic [15:0] v;

    intc_prio #(.DW(DW), .AW(AW), .NCH(NCH)) dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .addr   (addr),
        .we     (we),
        .dout   (dout),
        .intp_i (intp_i),
        .int_rdy(int_rdy),
        .int_vld(int_vld),
        .int_id (int_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
        din  = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [15:0] val);
        addr = a;
        we   = 1'b0;
        tick();
        val  = dout;
    endtask

    task automatic accept();
        int_rdy = 1'b1;
        tick();
        int_rdy = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        int n = 0;
        while (!int_vld && n < 20) begin
            tick();
            n++;
        end
        check_output(tag, 32'(int_vld), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; din = '0; addr = '0; we = 1'b0; intp_i = '0; int_rdy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_output("rst_vld", 32'(int_vld), 0);
        check_output("rst_id", 32'(int_id), 0);
        check_output("rst_dout", 32'(dout), 0);
        rd(0, v); check_output("rst_ctrl", 32'(v), 0);
        rd(2, v); check_output("rst_pend", 32'(v), 0);
        rd(4, v); check_output("rst_cfg0", 32'(v), 0);

        // Single-cycle pulse on channel 0: exact latency and holding request
        wr(4, 16'h0001);
        wr(0, 16'h0001);
        rd(4, v);  check_output("cfg0_rd", 32'(v), 32'h01);
        rd(1, v);  check_output("eoi_rd0", 32'(v), 0);
        rd(3, v);  check_output("unmapped3", 32'(v), 0);
        rd(12, v); check_output("unmapped12", 32'(v), 0);
        intp_i = 8'h01;
        tick();
        intp_i = '0;
        check_output("lat_e0_vld", 32'(int_vld), 0);
        repeat (SYNC) tick();
        tick();
        check_output("lat_e1_vld", 32'(int_vld), 0);
        tick();
        check_output("lat_e2_vld", 32'(int_vld), 1);
        check_output("lat_e2_id", 32'(int_id), 0);
        repeat (5) tick();
        check_output("hold_vld", 32'(int_vld), 1);
        rd(0, v); check_output("ctrl_req", 32'(v), 32'h0003);
        accept();
        check_output("act_vld", 32'(int_vld), 0);
        rd(2, v); check_output("pend_after_acc", 32'(v), 0);
        wr(1, 16'h0000);
        rd(0, v); check_output("ctrl_after_eoi", 32'(v), 32'h0001);

        // Priority: channel 5 (PRIO 0) beats channel 2 (PRIO 2)
        wr(4, 16'h0000);
        wr(6, 16'h0005);
        wr(9, 16'h0001);
        intp_i = 8'h24;
        tick();
        intp_i = '0;
        wait_vld("prio_vld1");
        check_output("prio_id5", 32'(int_id), 5);
        wr(1, 16'h0000);
        check_output("eoi_in_req", 32'(int_vld), 1);
        accept();
        check_output("prio_act_id", 32'(int_id), 5);
        wr(0, 16'h0000);
        rd(0, v); check_output("ctrl_act_gie0", 32'(v), 32'h0052);
        wr(1, 16'h0000);
        tick();
        check_output("idle_gie0_vld", 32'(int_vld), 0);
        rd(2, v); check_output("pend_ch2", 32'(v), 32'h0004);
        wr(0, 16'h0001);
        wait_vld("prio_vld2");
        check_output("prio_id2", 32'(int_id), 2);
        accept();
        wr(1, 16'h0000);
        wr(6, 16'h0000);
        wr(9, 16'h0000);

        // Rising edge on channel 3 held high: one request only
        wr(7, 16'h0011);
        intp_i = 8'h08;
        wait_vld("rise_vld");
        check_output("rise_id", 32'(int_id), 3);
        accept();
        wr(1, 16'h0000);
        repeat (5) tick();
        check_output("rise_no_rereq", 32'(int_vld), 0);
        rd(2, v); check_output("rise_pend", 32'(v), 0);
        intp_i = '0;
        tick();

        // Level-high on channel 3: set beats accept-clear, request re-arms
        wr(7, 16'h0001);
        intp_i = 8'h08;
        wait_vld("high_vld");
        check_output("high_id", 32'(int_id), 3);
        accept();
        check_output("high_act_vld", 32'(int_vld), 0);
        wr(1, 16'h0000);
        wait_vld("high_rearm");
        intp_i = '0;
        repeat (3) tick();
        accept();
        wr(1, 16'h0000);
        rd(2, v); check_output("high_pend_clr", 32'(v), 0);
        wr(7, 16'h0000);

        // Pending W1C with GIE off, write-hold of dout, same-cycle set/clear
        wr(0, 16'h0000);
        wr(5, 16'h0001);
        intp_i = 8'h02;
        tick();
        intp_i = '0;
        repeat (3 + SYNC) tick();
        check_output("gie0_no_req", 32'(int_vld), 0);
        rd(2, v); check_output("pend1_set", 32'(v), 32'h0002);
        wr(2, 16'h0002);
        check_output("dout_hold_we", 32'(dout), 32'h0002);
        rd(2, v); check_output("pend1_w1c", 32'(v), 0);
        check_output("w1c_no_req", 32'(int_vld), 0);
        intp_i = 8'h02;
        repeat (2 + SYNC) tick();
        wr(2, 16'h0002);
        rd(2, v); check_output("set_wins", 32'(v), 32'h0002);
        intp_i = '0;
        repeat (2 + SYNC) tick();
        wr(2, 16'h0002);
        rd(2, v); check_output("pend1_clr2", 32'(v), 0);

        // GIE dropped in REQ, disabled channel ineligible, reset in ACT
        wr(0, 16'h0001);
        intp_i = 8'h02;
        tick();
        intp_i = '0;
        wait_vld("gie_req_vld");
        check_output("gie_req_id", 32'(int_id), 1);
        wr(0, 16'h0000);
        check_output("gie0_drop_vld", 32'(int_vld), 0);
        rd(2, v); check_output("gie0_pend_kept", 32'(v), 32'h0002);
        wr(5, 16'h0000);
        wr(0, 16'h0001);
        repeat (3) tick();
        check_output("en0_ineligible", 32'(int_vld), 0);
        rd(2, v); check_output("en0_pend_kept", 32'(v), 32'h0002);
        wr(5, 16'h0001);
        wait_vld("reen_vld");
        accept();
        check_output("act_id1", 32'(int_id), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("rst_act_vld", 32'(int_vld), 0);
        check_output("rst_act_id", 32'(int_id), 0);
        check_output("rst_act_dout", 32'(dout), 0);
        rd(0, v); check_output("rst_act_ctrl", 32'(v), 0);
        rd(2, v); check_output("rst_act_pend", 32'(v), 0);
        rd(5, v); check_output("rst_act_cfg1", 32'(v), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
